// File: rtl/mic_pitch_detector.sv
// Pops stereo samples from the audio ADC FIFO, mixes them to mono and measures pitch period and peak
// from hysteresis rising crossings. Optional DC blocker enabled by defining MIC_PITCH_DC_BLOCK_EN.
module mic_pitch_detector #(
    parameter logic [31:0] THRESH     = 32'd10000000,
    parameter logic [15:0] MIN_PERIOD = 16'd8,
    parameter logic [15:0] MAX_PERIOD = 16'd4095
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        audio_in_available,
    input  logic [31:0] left_channel_audio_in,
    input  logic [31:0] right_channel_audio_in,
    output logic        read_audio_in,
    output logic        sample_strobe,
    output logic [15:0] period,
    output logic [31:0] peak,
    output logic        note_valid
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WAIT = 2'd2} state_t;

    localparam logic signed [32:0] THR_POS = $signed({1'b0, THRESH});
    localparam logic signed [32:0] THR_NEG = -THR_POS;
    localparam logic [16:0]        CNT_SAT = {1'b0, MAX_PERIOD} + 17'd1;

    state_t             state_reg, state_next;
    logic signed [32:0] sum;
    logic signed [31:0] mono;
    logic signed [31:0] x;
    logic signed [32:0] xw;
    logic [31:0]        mag;
    logic               is_low, is_high, crossing;
    logic [16:0]        cnt_inc;

    logic [15:0]        cnt_reg;
    logic [31:0]        runmax_reg;
    logic               below_reg;
    logic [15:0]        period_reg;
    logic [31:0]        peak_reg;
    logic               note_valid_reg;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next    = state_reg;
        read_audio_in = 1'b0;
        sample_strobe = 1'b0;
        case (state_reg)
            IDLE: if (audio_in_available) state_next = READ;
            READ: begin
                read_audio_in = 1'b1;
                state_next    = WAIT;
            end
            WAIT: begin
                sample_strobe = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bits [32:1] of the 33-bit sum are exactly (L+R)>>>1 truncated to 32 bits.
    assign sum  = $signed({left_channel_audio_in[31], left_channel_audio_in})
                + $signed({right_channel_audio_in[31], right_channel_audio_in});
    assign mono = sum[32:1];

`ifdef MIC_PITCH_DC_BLOCK_EN
    logic signed [31:0] acc_reg;

    assign x = mono - acc_reg;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)                 acc_reg <= '0;
        else if (state_reg == READ)  acc_reg <= acc_reg + (x >>> 8);
    end
`else
    assign x = mono;
`endif

    // Magnitude saturates so that -2^31 still fits the unsigned 31-bit range.
    always_comb begin
        mag = x;
        if (x == 32'sh8000_0000) mag = 32'h7FFF_FFFF;
        else if (x < 0)          mag = 32'(-x);
    end

    assign xw       = {x[31], x};
    assign is_low   = (xw < THR_NEG);
    assign is_high  = (xw > THR_POS);
    assign crossing = below_reg && is_high;
    assign cnt_inc  = {1'b0, cnt_reg} + 17'd1;

    // All tracking state advances on the READ edge, so outputs are new during the strobe cycle.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt_reg        <= '0;
            runmax_reg     <= '0;
            below_reg      <= 1'b0;
            period_reg     <= '0;
            peak_reg       <= '0;
            note_valid_reg <= 1'b0;
        end else if (state_reg == READ) begin
            if (crossing) begin
                period_reg     <= cnt_reg;
                peak_reg       <= runmax_reg;
                note_valid_reg <= (cnt_reg >= MIN_PERIOD);
                cnt_reg        <= 16'd1;
                runmax_reg     <= mag;
                below_reg      <= 1'b0;
            end else begin
                if (is_low)            below_reg  <= 1'b1;
                if (mag > runmax_reg)  runmax_reg <= mag;
                if ({1'b0, cnt_reg} < CNT_SAT) cnt_reg <= cnt_reg + 16'd1;
                if (cnt_inc >= CNT_SAT)        note_valid_reg <= 1'b0;
            end
        end
    end

    assign period     = period_reg;
    assign peak       = peak_reg;
    assign note_valid = note_valid_reg;
endmodule

// File: tb/tb_mic_pitch_detector.sv
// Self-checking bench for mic_pitch_detector: FIFO-style sample source, sample-level reference model,
// directed tone/silence/reset scenarios plus randomized waveforms.
module tb_mic_pitch_detector;
    localparam int          THR  = 10000000;
    localparam int          MINP = 8;
    localparam int          MAXP = 4095;
    localparam logic [31:0] POS  = 32'd100000000;
    localparam logic [31:0] NEG  = 32'(-100000000);
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        avail = 1'b0;
    logic [31:0] left = '0;
    logic [31:0] right = '0;
    logic        rd, strobe, valid;
    logic [15:0] period;
    logic [31:0] peak;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
    } samp_t;
    samp_t q[$];

    // reference model state: expected outputs after the last popped sample
    bit          m_below;
    longint      m_runmax;
    int          m_since;
    int          exp_period;
    logic [31:0] exp_peak;
    bit          exp_valid;
`ifdef MIC_PITCH_DC_BLOCK_EN
    int          m_acc;
`endif

    mic_pitch_detector dut (
        .CLOCK_50              (clk),
        .resetn                (resetn),
        .audio_in_available    (avail),
        .left_channel_audio_in (left),
        .right_channel_audio_in(right),
        .read_audio_in         (rd),
        .sample_strobe         (strobe),
        .period                (period),
        .peak                  (peak),
        .note_valid            (valid)
    );

    always #10 clk = ~clk;

    task automatic model_reset();
        m_below    = 1'b0;
        m_runmax   = 0;
        m_since    = 0;
        exp_period = 0;
        exp_peak   = '0;
        exp_valid  = 1'b0;
`ifdef MIC_PITCH_DC_BLOCK_EN
        m_acc      = 0;
`endif
    endtask

    // Sample-level behaviour: mono mix, hysteresis, period = samples between rising crossings.
    task automatic model_step(input logic [31:0] l, input logic [31:0] r);
        longint s, ax;
        int     m, x;
        s = longint'($signed(l)) + longint'($signed(r));
        m = int'(s >>> 1);
`ifdef MIC_PITCH_DC_BLOCK_EN
        x     = m - m_acc;
        m_acc = m_acc + (x >>> 8);
`else
        x = m;
`endif
        ax = (x < 0) ? -longint'(x) : longint'(x);
        if (ax > 64'sd2147483647) ax = 64'sd2147483647;
        if (m_below && x > THR) begin
            exp_period = (m_since > MAXP + 1) ? MAXP + 1 : m_since;
            exp_valid  = (exp_period >= MINP);
            exp_peak   = m_runmax[31:0];
            m_runmax   = ax;
            m_since    = 1;
            m_below    = 1'b0;
        end else begin
            if (x < -THR) m_below = 1'b1;
            if (ax > m_runmax) m_runmax = ax;
            m_since++;
            if (m_since >= MAXP + 1) exp_valid = 1'b0;
        end
    endtask

    // FIFO front is presented on the falling edge; a pop happens on the rising edge that sees read_audio_in.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            avail = 1'b1;
            left  = q[0].l;
            right = q[0].r;
        end else begin
            avail = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (resetn && rd && q.size() > 0) begin
            model_step(q[0].l, q[0].r);
            q.delete(0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] l, input logic [31:0] r);
        samp_t s;
        bit    got;
        s.l = l;
        s.r = r;
        q.push_back(s);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (strobe) got = 1'b1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL feed_timeout strobe=0 required=1");
        end
    endtask

    task automatic feed_run(input logic [31:0] l, input logic [31:0] r, input int n);
        for (int i = 0; i < n; i++) feed(l, r);
    endtask

    task automatic test_reset();
        repeat (3) tick();
        total += 5;
        if (rd !== 1'b0)      begin bad++; $display("FAIL reset_read got=%b exp=0", rd); end
        if (strobe !== 1'b0)  begin bad++; $display("FAIL reset_strobe got=%b exp=0", strobe); end
        if (period !== 16'd0) begin bad++; $display("FAIL reset_period got=%0d exp=0", period); end
        if (peak !== 32'd0)   begin bad++; $display("FAIL reset_peak got=%0d exp=0", peak); end
        if (valid !== 1'b0)   begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        resetn = 1'b1;
        tick();
        $display("reset: checked outputs, released");
    endtask

    task automatic test_idle();
        int reads = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rd) reads++;
        end
        total++;
        if (reads !== 0) begin bad++; $display("FAIL idle_no_pop got=%0d exp=0", reads); end
        $display("idle: pops with empty fifo=%0d", reads);
    endtask

    task automatic test_back_to_back();
        samp_t s;
        int    reads = 0, miss = 0;
        bit    prev_rd = 1'b0;
        s.l = '0;
        s.r = '0;
        for (int i = 0; i < 20; i++) q.push_back(s);
        tick();
        for (int i = 0; i < 30; i++) begin
            if (rd) reads++;
            if (prev_rd != strobe) miss++;
            prev_rd = rd;
            tick();
        end
        total += 2;
        if (reads !== 10) begin bad++; $display("FAIL b2b_pops got=%0d exp=10", reads); end
        if (miss !== 0)   begin bad++; $display("FAIL b2b_strobe_follow got=%0d exp=0", miss); end
        for (int i = 0; i < 200 && q.size() > 0; i++) tick();
        repeat (3) tick();
        total += 2;
        if (q.size() !== 0)            begin bad++; $display("FAIL b2b_drain got=%0d exp=0", q.size()); end
        if (period !== 16'(exp_period)) begin bad++; $display("FAIL b2b_period got=%0d exp=%0d", period, exp_period); end
        $display("back_to_back: pops in 30 cycles=%0d strobe_miss=%0d", reads, miss);
    endtask

    task automatic test_square40();
        feed_run(NEG, NEG, 20);
        feed_run(POS, POS, 20);
        feed_run(NEG, NEG, 20);
        feed_run(POS, POS, 1);
        total += 3;
        if (period !== 16'(exp_period)) begin bad++; $display("FAIL sq40_model_period got=%0d exp=%0d", period, exp_period); end
        if (peak !== exp_peak)          begin bad++; $display("FAIL sq40_model_peak got=%0d exp=%0d", peak, exp_peak); end
        if (valid !== exp_valid)        begin bad++; $display("FAIL sq40_model_valid got=%b exp=%b", valid, exp_valid); end
`ifndef MIC_PITCH_DC_BLOCK_EN
        total += 3;
        if (period !== 16'd40)   begin bad++; $display("FAIL sq40_period got=%0d exp=40", period); end
        if (peak !== 32'd100000000) begin bad++; $display("FAIL sq40_peak got=%0d exp=100000000", peak); end
        if (valid !== 1'b1)      begin bad++; $display("FAIL sq40_valid got=%b exp=1", valid); end
`endif
        $display("square40: period=%0d peak=%0d valid=%b", period, peak, valid);
    endtask

    task automatic test_short_period();
        for (int c = 0; c < 4; c++) begin
            feed_run(NEG, NEG, 2);
            feed_run(POS, POS, 2);
        end
        feed_run(NEG, NEG, 2);
        feed_run(POS, POS, 1);
        total += 2;
        if (period !== 16'(exp_period)) begin bad++; $display("FAIL short_model_period got=%0d exp=%0d", period, exp_period); end
        if (valid !== exp_valid)        begin bad++; $display("FAIL short_model_valid got=%b exp=%b", valid, exp_valid); end
`ifndef MIC_PITCH_DC_BLOCK_EN
        total += 2;
        if (period !== 16'd4) begin bad++; $display("FAIL short_period got=%0d exp=4", period); end
        if (valid !== 1'b0)   begin bad++; $display("FAIL short_valid got=%b exp=0", valid); end
`endif
        $display("short_period: period=%0d valid=%b", period, valid);
    endtask

    task automatic test_extreme();
        logic [15:0] p_snap;
        logic [31:0] k_snap;
        feed_run(MINV, MINV, 3);
        feed_run(POS, POS, 1);
        total++;
        if (peak !== exp_peak) begin bad++; $display("FAIL ext_model_peak got=%h exp=%h", peak, exp_peak); end
`ifndef MIC_PITCH_DC_BLOCK_EN
        total++;
        if (peak !== 32'h7FFF_FFFF) begin bad++; $display("FAIL ext_peak_sat got=%h exp=7fffffff", peak); end
`endif
        p_snap = period;
        k_snap = peak;
        feed_run(NEG, NEG, 1);
        feed_run(POS, NEG, 5);
        total += 2;
        if (period !== 16'(exp_period)) begin bad++; $display("FAIL cancel_model_period got=%0d exp=%0d", period, exp_period); end
        if (peak !== exp_peak)          begin bad++; $display("FAIL cancel_model_peak got=%0d exp=%0d", peak, exp_peak); end
`ifndef MIC_PITCH_DC_BLOCK_EN
        total += 2;
        if (period !== p_snap) begin bad++; $display("FAIL cancel_no_cross_period got=%0d exp=%0d", period, p_snap); end
        if (peak !== k_snap)   begin bad++; $display("FAIL cancel_no_cross_peak got=%0d exp=%0d", peak, k_snap); end
`endif
        $display("extreme: saturated peak=%h, cancelling channels period=%0d", k_snap, period);
    endtask

    task automatic test_silence();
        int fall_at = 0;
        feed_run(NEG, NEG, 20);
        feed_run(POS, POS, 20);
        feed_run(NEG, NEG, 20);
        feed_run(POS, POS, 1);
        for (int k = 1; k <= 4100; k++) begin
            feed(32'd0, 32'd0);
            if (valid === 1'b0 && fall_at == 0) fall_at = k;
        end
        total += 3;
        if (valid !== exp_valid)        begin bad++; $display("FAIL silence_model_valid got=%b exp=%b", valid, exp_valid); end
        if (period !== 16'(exp_period)) begin bad++; $display("FAIL silence_model_period got=%0d exp=%0d", period, exp_period); end
        if (peak !== exp_peak)          begin bad++; $display("FAIL silence_model_peak got=%0d exp=%0d", peak, exp_peak); end
`ifndef MIC_PITCH_DC_BLOCK_EN
        total += 3;
        if (fall_at !== 4095)       begin bad++; $display("FAIL silence_fall_sample got=%0d exp=4095", fall_at); end
        if (period !== 16'd40)      begin bad++; $display("FAIL silence_period_hold got=%0d exp=40", period); end
        if (peak !== 32'd100000000) begin bad++; $display("FAIL silence_peak_hold got=%0d exp=100000000", peak); end
`endif
        $display("silence: note_valid fell after %0d zero samples, period=%0d", fall_at, period);
    endtask

    task automatic test_random();
        int          half = 4, cnt = 0, sgn = -1, amp = 50000000;
        int          v, dl, errs = 0;
        logic [31:0] l, r;
        for (int i = 0; i < 600; i++) begin
            if (cnt == half) begin
                cnt  = 0;
                sgn  = -sgn;
                half = int'($urandom_range(2, 30));
                amp  = int'($urandom_range(5000000, 1500000000));
            end
            cnt++;
            if ($urandom_range(0, 15) == 0) begin
                l = $urandom;
                r = $urandom;
            end else begin
                v  = sgn * amp + int'($urandom_range(0, 2000000)) - 1000000;
                dl = int'($urandom_range(0, 2000000)) - 1000000;
                l  = 32'(v + dl);
                r  = 32'(v - dl);
            end
            feed(l, r);
            total += 3;
            if (period !== 16'(exp_period)) begin bad++; errs++; $display("FAIL rand_period i=%0d got=%0d exp=%0d", i, period, exp_period); end
            if (peak !== exp_peak)          begin bad++; errs++; $display("FAIL rand_peak i=%0d got=%0d exp=%0d", i, peak, exp_peak); end
            if (valid !== exp_valid)        begin bad++; errs++; $display("FAIL rand_valid i=%0d got=%b exp=%b", i, valid, exp_valid); end
        end
        $display("random: 600 samples, mismatching checks=%0d", errs);
    endtask

    task automatic test_reset_mid_read();
        samp_t s;
        bit    seen = 1'b0;
        bit    got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            s.l = ((i / 5) % 2 == 0) ? NEG : POS;
            s.r = s.l;
            q.push_back(s);
        end
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (rd) seen = 1'b1;
        end
        total++;
        if (!seen) begin bad++; $display("FAIL midread_wait got=0 exp=1"); end
        resetn = 1'b0;
        #1;
        total += 5;
        if (rd !== 1'b0)      begin bad++; $display("FAIL midread_read got=%b exp=0", rd); end
        if (strobe !== 1'b0)  begin bad++; $display("FAIL midread_strobe got=%b exp=0", strobe); end
        if (period !== 16'd0) begin bad++; $display("FAIL midread_period got=%0d exp=0", period); end
        if (peak !== 32'd0)   begin bad++; $display("FAIL midread_peak got=%0d exp=0", peak); end
        if (valid !== 1'b0)   begin bad++; $display("FAIL midread_valid got=%b exp=0", valid); end
        q.delete();
        model_reset();
        s.l = POS;
        s.r = POS;
        q.push_back(s);
        tick();
        tick();
        resetn = 1'b1;
        #1;
        total++;
        if (rd !== 1'b0) begin bad++; $display("FAIL release_early_pop got=%b exp=0", rd); end
        @(posedge clk);
        #1;
        total++;
        if (rd !== 1'b1) begin bad++; $display("FAIL release_pop_second_edge got=%b exp=1", rd); end
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (strobe) got = 1'b1;
        end
        total += 4;
        if (!got)                       begin bad++; $display("FAIL release_strobe got=0 exp=1"); end
        if (period !== 16'(exp_period)) begin bad++; $display("FAIL release_period got=%0d exp=%0d", period, exp_period); end
        if (peak !== exp_peak)          begin bad++; $display("FAIL release_peak got=%0d exp=%0d", peak, exp_peak); end
        if (valid !== exp_valid)        begin bad++; $display("FAIL release_valid got=%b exp=%b", valid, exp_valid); end
        $display("reset_mid_read: aborted pop, first new pop on second edge after release");
    endtask

`ifdef MIC_PITCH_DC_BLOCK_EN
    task automatic test_dc_block();
        logic [31:0] hi, lo;
        hi = 32'd150000000;
        lo = 32'(-50000000);
        for (int c = 0; c < 30; c++) begin
            feed_run(lo, lo, 20);
            feed_run(hi, hi, 20);
        end
        feed_run(lo, lo, 20);
        feed_run(hi, hi, 1);
        total += 4;
        if (period !== 16'd40)          begin bad++; $display("FAIL dc_period got=%0d exp=40", period); end
        if (valid !== 1'b1)             begin bad++; $display("FAIL dc_valid got=%b exp=1", valid); end
        if (period !== 16'(exp_period)) begin bad++; $display("FAIL dc_model_period got=%0d exp=%0d", period, exp_period); end
        if (peak !== exp_peak)          begin bad++; $display("FAIL dc_model_peak got=%0d exp=%0d", peak, exp_peak); end
        $display("dc_block: offset tone period=%0d peak=%0d", period, peak);
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_back_to_back();
        test_square40();
        test_short_period();
        test_extreme();
        test_silence();
        test_random();
        test_reset_mid_read();
`ifdef MIC_PITCH_DC_BLOCK_EN
        test_dc_block();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
